hplvds_rx_lane_ctrl: RTL and testbench

//  Digital controller for N_LANES HPLVDS receiver pad cells. Sequences power-up of each pad
//  (RTERM -> RX -> EI detect) and synchronises the single-bit pad outputs. Applies lane

---
 rtl/hplvds_rx_pkg.sv | 11 +
 rtl/hplvds_rx_lane.sv | 50 +++++
 rtl/hplvds_rx_lane_ctrl.sv | 89 ++++++++
 tb/tb_hplvds_rx_lane_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hplvds_rx_pkg.sv
// hplvds_rx_pkg: shared FSM state type, trim width and a constant-safe clog2
// for the HPLVDS receive lane controller.
package hplvds_rx_pkg;
    typedef enum logic [1:0] {OFF, TERM, SETTLE, ACTIVE} state_e;
    localparam int RTERM_TRIM_W = 4;
    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/hplvds_rx_lane.sv
// hplvds_rx_lane: one pad lane - synchronisers, polarity, electrical-idle
// filter (slow entry, fast exit) and the deserialising shift register.
module hplvds_rx_lane
    import hplvds_rx_pkg::*;
#(
    parameter int DES_W   = 8,
    parameter int EI_FILT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pol,
    input  logic             di,
    input  logic             ei,
    input  logic             run,
    input  logic             cap,
    output logic             ei_o,
    output logic [DES_W-1:0] data_o
);
    localparam int CW = clog2(EI_FILT + 1);
    logic             di_s1_q, di_s2_q, ei_s1_q, ei_s2_q;
    logic             ei_q, ei_d, bit_v;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DES_W-1:0] sr_q, sr_d, data_q, data_d;
    always_comb begin
        bit_v  = di_s2_q ^ pol;
        sr_d   = {bit_v, sr_q[DES_W-1:1]};
        cnt_d  = !(run && ei_s2_q) ? '0 : (cnt_q == CW'(EI_FILT)) ? cnt_q : cnt_q + 1'b1;
        ei_d   = cnt_d == CW'(EI_FILT);
        data_d = !cap ? data_q : ei_q ? '0 : sr_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            {di_s1_q, di_s2_q, ei_s1_q, ei_s2_q, ei_q} <= '0;
            cnt_q  <= '0;
            sr_q   <= '0;
            data_q <= '0;
        end else begin
            di_s1_q <= di;
            di_s2_q <= di_s1_q;
            ei_s1_q <= ei;
            ei_s2_q <= ei_s1_q;
            ei_q    <= ei_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
        end
    end
    assign ei_o   = ei_q;
    assign data_o = data_q;
endmodule

// File: rtl/hplvds_rx_lane_ctrl.sv
// hplvds_rx_lane_ctrl: power-up sequencer (RTERM -> RX -> EI detect) for the
// HPLVDS RX pads, shared word-boundary counter and per-lane deserialisers.
module hplvds_rx_lane_ctrl
    import hplvds_rx_pkg::*;
#(
    parameter int N_LANES    = 4,
    parameter int DES_W      = 8,
    parameter int TERM_CYC   = 16,
    parameter int SETTLE_CYC = 64,
    parameter int EI_FILT    = 4
) (
    input  logic                      CLK_I,
    input  logic                      RST_I,
    input  logic                      EN_I,
    input  logic [RTERM_TRIM_W-1:0]   RTERM_TRIM_I,
    input  logic [N_LANES-1:0]        POL_I,
    input  logic [N_LANES-1:0]        DI_I,
    input  logic [N_LANES-1:0]        EI_I,
    output logic                      RTERM_EN_O,
    output logic [RTERM_TRIM_W-1:0]   RTERM_TRIM_O,
    output logic                      RX_EN_O,
    output logic                      EI_DETECT_EN_O,
    output logic                      READY_O,
    output logic [N_LANES-1:0]        EI_O,
    output logic [N_LANES*DES_W-1:0]  DATA_O,
    output logic                      DATA_VLD_O
);
    localparam int TW = clog2((TERM_CYC > SETTLE_CYC ? TERM_CYC : SETTLE_CYC) + 1);
    localparam int BW = clog2(DES_W);
    state_e                  state_q, state_d;
    logic [TW-1:0]           tmr_q, tmr_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [RTERM_TRIM_W-1:0] trim_q, trim_d;
    logic                    rterm_q, rterm_d, rx_q, rx_d, act_q, act_d, vld_q, vld_d;
    logic                    tmr_last, run, cap;
    always_comb begin
        tmr_last = (state_q == TERM && tmr_q == TW'(TERM_CYC - 1)) ||
                   (state_q == SETTLE && tmr_q == TW'(SETTLE_CYC - 1));
        state_d  = !EN_I ? OFF : (state_q == OFF) ? TERM :
                   tmr_last ? state_e'(state_q + 2'd1) : state_q;
        tmr_d    = (!EN_I || tmr_last || state_q == OFF || state_q == ACTIVE) ? '0 : tmr_q + 1'b1;
        // Counting only while ACTIVE persists keeps a capture from firing on the exit cycle
        run      = state_q == ACTIVE && state_d == ACTIVE;
        cap      = run && bit_q == BW'(DES_W - 1);
        bit_d    = !run ? '0 : cap ? '0 : bit_q + 1'b1;
        trim_d   = (state_q == OFF && state_d == TERM) ? RTERM_TRIM_I : trim_q;
        rterm_d  = state_d != OFF;
        rx_d     = state_d inside {SETTLE, ACTIVE};
        act_d    = state_d == ACTIVE;
        vld_d    = cap;
    end
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= OFF;
            tmr_q   <= '0;
            bit_q   <= '0;
            trim_q  <= '0;
            {rterm_q, rx_q, act_q, vld_q} <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            trim_q  <= trim_d;
            rterm_q <= rterm_d;
            rx_q    <= rx_d;
            act_q   <= act_d;
            vld_q   <= vld_d;
        end
    end
    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        hplvds_rx_lane #(.DES_W(DES_W), .EI_FILT(EI_FILT)) u_lane (
            .clk    (CLK_I),
            .rst    (RST_I),
            .pol    (POL_I[k]),
            .di     (DI_I[k]),
            .ei     (EI_I[k]),
            .run    (run),
            .cap    (cap),
            .ei_o   (EI_O[k]),
            .data_o (DATA_O[k*DES_W +: DES_W])
        );
    end
    assign RTERM_EN_O     = rterm_q;
    assign RTERM_TRIM_O   = trim_q;
    assign RX_EN_O        = rx_q;
    assign EI_DETECT_EN_O = act_q;
    assign READY_O        = act_q;
    assign DATA_VLD_O     = vld_q;
endmodule

// File: tb/tb_hplvds_rx_lane_ctrl.sv
// tb_hplvds_rx_lane_ctrl: randomized bench; expected words and idle flags come
// from a per-edge history of the pad inputs and the stated latencies.
module tb_hplvds_rx_lane_ctrl;
    localparam int N = 4, W = 8, TC = 16, SC = 64, EF = 4, HM = 1023;
    logic             CLK_I = 1'b0;
    logic             RST_I, EN_I;
    logic [3:0]       RTERM_TRIM_I, RTERM_TRIM_O;
    logic [N-1:0]     POL_I, DI_I, EI_I, EI_O;
    logic             RTERM_EN_O, RX_EN_O, EI_DETECT_EN_O, READY_O, DATA_VLD_O;
    logic [N*W-1:0]   DATA_O;

    hplvds_rx_lane_ctrl dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .EN_I(EN_I), .RTERM_TRIM_I(RTERM_TRIM_I),
        .POL_I(POL_I), .DI_I(DI_I), .EI_I(EI_I), .RTERM_EN_O(RTERM_EN_O),
        .RTERM_TRIM_O(RTERM_TRIM_O), .RX_EN_O(RX_EN_O), .EI_DETECT_EN_O(EI_DETECT_EN_O),
        .READY_O(READY_O), .EI_O(EI_O), .DATA_O(DATA_O), .DATA_VLD_O(DATA_VLD_O)
    );

    always #5 CLK_I = ~CLK_I;

    int checks = 0, failures = 0;
    int cyc = 0, en_edge = 0, act_edge = 0;
    logic [N*W-1:0] exp_data = '0;
    logic [N-1:0]   hist_di [1024];
    logic [N-1:0]   hist_ei [1024];

    // Edge n latches whatever the pads present at edge n
    always @(posedge CLK_I) begin
        cyc = cyc + 1;
        hist_di[cyc & HM] = DI_I;
        hist_ei[cyc & HM] = EI_I;
    end

    // Idle is flagged once the last EF synchronised samples were all high
    function automatic logic ei_model(int t, int k);
        for (int i = 1; i <= EF; i++) if (!hist_ei[(t - 1 - i) & HM][k]) return 1'b0;
        return 1'b1;
    endfunction

    // Word visible after edge c: bits from edges c-W-1 .. c-2, first = LSB
    function automatic logic [N*W-1:0] word_model(int c);
        logic [N*W-1:0] w = '0;
        for (int k = 0; k < N; k++)
            for (int j = 0; j < W; j++)
                w[k*W + j] = ei_model(c - 1, k) ? 1'b0 : hist_di[(c - W - 1 + j) & HM][k] ^ POL_I[k];
        return w;
    endfunction

    function automatic logic vld_model(int c);
        return c > act_edge && (c - act_edge) % W == 0;
    endfunction

    task automatic test_reset();
        RST_I = 1'b1; EN_I = 1'b1; RTERM_TRIM_I = 4'd5; DI_I = '0; EI_I = '0;
        POL_I = {2'($urandom), 2'b10};
        repeat (3) @(negedge CLK_I);
        checks++;
        if ({RTERM_EN_O, RTERM_TRIM_O, RX_EN_O, EI_DETECT_EN_O, READY_O, EI_O, DATA_O, DATA_VLD_O} !== '0) begin
            failures++;
            $display("FAIL reset_state: outputs=%h required 0",
                     {RTERM_EN_O, RTERM_TRIM_O, RX_EN_O, EI_DETECT_EN_O, READY_O, EI_O, DATA_O, DATA_VLD_O});
        end
        RST_I = 1'b0;
        en_edge = cyc + 1;
        act_edge = en_edge + TC + SC;
    endtask

    task automatic test_powerup();
        for (int i = 0; i < TC + SC + 3; i++) begin
            @(negedge CLK_I);
            checks++;
            if ({RTERM_EN_O, RX_EN_O, EI_DETECT_EN_O, READY_O, DATA_VLD_O, RTERM_TRIM_O} !==
                {cyc >= en_edge, cyc >= en_edge + TC, cyc >= act_edge, cyc >= act_edge, 1'b0, 4'd5}) begin
                failures++;
                $display("FAIL powerup cyc=%0d: rterm/rx/eid/rdy/vld/trim=%b%b%b%b%b/%0d", cyc,
                         RTERM_EN_O, RX_EN_O, EI_DETECT_EN_O, READY_O, DATA_VLD_O, RTERM_TRIM_O);
            end
        end
    endtask

    task automatic test_data_pol();
        logic [W-1:0] pat = 8'h4D;
        int nw = 0;
        for (int i = 0; i < 3 * W + 4; i++) begin
            @(negedge CLK_I);
            checks++;
            if (DATA_VLD_O !== vld_model(cyc)) begin
                failures++;
                $display("FAIL data_vld cyc=%0d: got %b required %b", cyc, DATA_VLD_O, vld_model(cyc));
            end
            if (vld_model(cyc)) begin
                exp_data = word_model(cyc);
                if (nw > 0) begin
                    checks++;
                    if (DATA_O[W-1:0] !== 8'h4D || DATA_O[2*W-1:W] !== 8'hB2) begin
                        failures++;
                        $display("FAIL data_pol: lane0=%h lane1=%h required 4d b2", DATA_O[W-1:0], DATA_O[2*W-1:W]);
                    end
                end
                nw++;
            end
            checks++;
            if (DATA_O !== exp_data) begin
                failures++;
                $display("FAIL data_word cyc=%0d: got %h required %h", cyc, DATA_O, exp_data);
            end
            DI_I = N'($urandom);
            DI_I[0] = pat[(cyc + 2 - act_edge) % W];
            DI_I[1] = DI_I[0];
        end
    endtask

    task automatic test_ei_filter();
        int lens [6] = '{3, 6, 20, 8, 0, 8};
        lens[4] = $urandom_range(1, 8);
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < lens[s]; i++) begin
                @(negedge CLK_I);
                for (int k = 0; k < N; k++) begin
                    checks++;
                    if (EI_O[k] !== ei_model(cyc, k)) begin
                        failures++;
                        $display("FAIL ei_flag cyc=%0d lane=%0d: got %b required %b", cyc, k, EI_O[k], ei_model(cyc, k));
                    end
                end
                if (vld_model(cyc)) exp_data = word_model(cyc);
                checks++;
                if (DATA_VLD_O !== vld_model(cyc) || DATA_O !== exp_data) begin
                    failures++;
                    $display("FAIL ei_word cyc=%0d: vld=%b data=%h required vld=%b data=%h",
                             cyc, DATA_VLD_O, DATA_O, vld_model(cyc), exp_data);
                end
                DI_I = N'($urandom);
                EI_I = '0;
                EI_I[2] = (s % 2 == 0);
            end
        end
    endtask

    task automatic test_abort();
        RTERM_TRIM_I = 4'd9;
        EI_I = '1;
        for (int i = 0; i < EF + 3; i++) begin
            @(negedge CLK_I);
            if (vld_model(cyc)) exp_data = word_model(cyc);
            checks++;
            if (EI_O !== {ei_model(cyc, 3), ei_model(cyc, 2), ei_model(cyc, 1), ei_model(cyc, 0)} ||
                RTERM_TRIM_O !== 4'd5 || DATA_O !== exp_data) begin
                failures++;
                $display("FAIL abort_pre cyc=%0d: ei=%b trim=%0d data=%h required trim 5 data %h",
                         cyc, EI_O, RTERM_TRIM_O, DATA_O, exp_data);
            end
            DI_I = N'($urandom);
        end
        EN_I = 1'b0;
        @(negedge CLK_I);
        checks++;
        if ({RTERM_EN_O, RX_EN_O, EI_DETECT_EN_O, READY_O, DATA_VLD_O, EI_O} !== '0 || DATA_O !== exp_data) begin
            failures++;
            $display("FAIL abort_active: en=%b%b%b%b vld=%b ei=%b data=%h required zeros, data %h",
                     RTERM_EN_O, RX_EN_O, EI_DETECT_EN_O, READY_O, DATA_VLD_O, EI_O, DATA_O, exp_data);
        end
        EI_I = '0;
        EN_I = 1'b1;
        en_edge = cyc + 1;
        for (int i = 0; i < TC + 5; i++) begin
            @(negedge CLK_I);
            checks++;
            if ({RTERM_EN_O, RX_EN_O, READY_O, RTERM_TRIM_O} !== {1'b1, cyc >= en_edge + TC, 1'b0, 4'd9}) begin
                failures++;
                $display("FAIL abort_seq cyc=%0d: rterm/rx/rdy=%b%b%b trim=%0d required trim 9",
                         cyc, RTERM_EN_O, RX_EN_O, READY_O, RTERM_TRIM_O);
            end
        end
        EN_I = 1'b0;
        @(negedge CLK_I);
        checks++;
        if ({RTERM_EN_O, RX_EN_O, EI_DETECT_EN_O, READY_O, DATA_VLD_O} !== '0 || RTERM_TRIM_O !== 4'd9) begin
            failures++;
            $display("FAIL abort_settle: en=%b%b%b%b vld=%b trim=%0d required zeros, trim 9",
                     RTERM_EN_O, RX_EN_O, EI_DETECT_EN_O, READY_O, DATA_VLD_O, RTERM_TRIM_O);
        end
        EN_I = 1'b1;
        en_edge = cyc + 1;
        act_edge = en_edge + TC + SC;
        for (int i = 0; i < TC + SC + 2; i++) begin
            @(negedge CLK_I);
            checks++;
            if ({RTERM_EN_O, RX_EN_O, EI_DETECT_EN_O, READY_O, DATA_VLD_O, RTERM_TRIM_O} !==
                {1'b1, cyc >= en_edge + TC, cyc >= act_edge, cyc >= act_edge, 1'b0, 4'd9}) begin
                failures++;
                $display("FAIL abort_repeat cyc=%0d: rterm/rx/eid/rdy/vld=%b%b%b%b%b trim=%0d", cyc,
                         RTERM_EN_O, RX_EN_O, EI_DETECT_EN_O, READY_O, DATA_VLD_O, RTERM_TRIM_O);
            end
            DI_I = N'($urandom);
        end
    endtask

    task automatic test_reset_mid();
        int budget = 2 * W;
        while ((cyc - act_edge) % W != 3 && budget > 0) begin
            @(negedge CLK_I);
            budget--;
        end
        checks++;
        if (budget == 0) begin
            failures++;
            $display("FAIL reset_mid_align: no mid-word point found, cyc=%0d", cyc);
        end
        RST_I = 1'b1;
        @(negedge CLK_I);
        checks++;
        if ({RTERM_EN_O, RTERM_TRIM_O, RX_EN_O, EI_DETECT_EN_O, READY_O, EI_O, DATA_O, DATA_VLD_O} !== '0) begin
            failures++;
            $display("FAIL reset_mid: outputs=%h required 0",
                     {RTERM_EN_O, RTERM_TRIM_O, RX_EN_O, EI_DETECT_EN_O, READY_O, EI_O, DATA_O, DATA_VLD_O});
        end
        exp_data = '0;
        RST_I = 1'b0;
        en_edge = cyc + 1;
        act_edge = en_edge + TC + SC;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge CLK_I);
            checks++;
            if (DATA_VLD_O !== 1'b0 || RTERM_EN_O !== 1'b1) begin
                failures++;
                $display("FAIL reset_partial cyc=%0d: vld=%b rterm=%b required 0 1", cyc, DATA_VLD_O, RTERM_EN_O);
            end
        end
    endtask

    task automatic test_back_to_back();
        int strobes = 0;
        int stop = act_edge + 3 * W + 2;
        while (cyc < stop) begin
            @(negedge CLK_I);
            if (vld_model(cyc)) exp_data = word_model(cyc);
            strobes += int'(DATA_VLD_O === 1'b1);
            checks++;
            if (DATA_VLD_O !== vld_model(cyc) || DATA_O !== exp_data || READY_O !== (cyc >= act_edge)) begin
                failures++;
                $display("FAIL b2b cyc=%0d: vld=%b rdy=%b data=%h required vld=%b data=%h",
                         cyc, DATA_VLD_O, READY_O, DATA_O, vld_model(cyc), exp_data);
            end
            DI_I = N'($urandom);
        end
        checks++;
        if (strobes != 3) begin
            failures++;
            $display("FAIL b2b_count: strobes=%0d required 3", strobes);
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_data_pol();
        test_ei_filter();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
